// File: rtl/dec_sel_arbiter.sv
// Round-robin sequencer sharing a 2-to-4 polarity select decoder among 4 requesters.
// Optional GNT_CHECK_EN adds a decoder-output check (dec_d in, sticky chk_err out).
module dec_sel_arbiter #(
   parameter int HOLD_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       cfg_pol,
   output logic [3:0] gnt,
   output logic       gnt_vld,
   output logic       dec_a2,
   output logic       dec_a1,
   output logic       dec_a0
`ifdef GNT_CHECK_EN
   ,
   input  logic [3:0] dec_d,
   output logic       chk_err
`endif
);

   localparam int CW = $clog2(HOLD_CYC + 1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t          state_q, state_d;
   logic [1:0]      cur_q, cur_d, last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      gnt_d;
   logic            vld_d, a2_d;
   logic [1:0]      addr_q, addr_d;
   logic [1:0]      win, idx;
   logic            found;

   // Decoder swaps lines 0 and 1, so ch0/ch1 use swapped addresses.
   function automatic logic [1:0] ch_addr(input logic [1:0] ch);
      case (ch)
         2'd0:    ch_addr = 2'b01;
         2'd1:    ch_addr = 2'b00;
         2'd2:    ch_addr = 2'b10;
         default: ch_addr = 2'b11;
      endcase
   endfunction

   // Scan last+1 .. last+4 (wrapping); the final step revisits last itself.
   always_comb begin
      win   = last_q;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = GRANT;
         GRANT:   if (!req[cur_q] || cnt_q == '0) state_d = GAP;
         GAP:     state_d = (|req) ? GRANT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of all registered outputs and datapath state.
   always_comb begin
      cur_d  = cur_q;
      last_d = last_q;
      cnt_d  = cnt_q;
      gnt_d  = gnt;
      vld_d  = gnt_vld;
      a2_d   = dec_a2;
      addr_d = addr_q;
      if (state_q != GRANT && state_d == GRANT) begin
         cur_d  = win;
         cnt_d  = CW'(HOLD_CYC - 1);
         gnt_d  = 4'b0001 << win;
         vld_d  = 1'b1;
         a2_d   = cfg_pol;
         addr_d = ch_addr(win);
      end else if (state_q == GRANT && state_d == GRANT) begin
         cnt_d = cnt_q - 1'b1;
      end else if (state_q == GRANT && state_d == GAP) begin
         gnt_d  = '0;
         vld_d  = 1'b0;
         last_d = cur_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q   <= 2'd0;
         last_q  <= 2'd3;
         cnt_q   <= '0;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         dec_a2  <= 1'b1;
         addr_q  <= 2'b01;
      end else begin
         cur_q   <= cur_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt     <= gnt_d;
         gnt_vld <= vld_d;
         dec_a2  <= a2_d;
         addr_q  <= addr_d;
      end
   end

   assign {dec_a1, dec_a0} = addr_q;

`ifdef GNT_CHECK_EN
   logic [3:0] dec_exp;
   assign dec_exp = dec_a2 ? gnt : ~gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              chk_err <= 1'b0;
      else if (gnt_vld && dec_d != dec_exp) chk_err <= 1'b1;
   end
`endif

endmodule
